// File: rtl/alarm_bank.sv
// Multi-channel alarm engine: per-channel arm/ring/snooze FSMs compared
// against the running time, with global snooze and dismiss.
module alarm_bank #(
   parameter int NUM_ALARMS   = 4,
   parameter int TIME_W       = 6,
   parameter int SNOOZE_SECS  = 300,
   parameter int RING_TIMEOUT = 60,
   parameter int MAX_SNOOZE   = 3,
   localparam int CNT_MAX     = (SNOOZE_SECS > RING_TIMEOUT) ?
                                SNOOZE_SECS : RING_TIMEOUT,
   localparam int CW          = $clog2(CNT_MAX + 1),
   localparam int SW          = (MAX_SNOOZE > 0) ?
                                $clog2(MAX_SNOOZE + 1) : 1,
   localparam int AW          = (NUM_ALARMS > 1) ?
                                $clog2(NUM_ALARMS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic [TIME_W-1:0]            hour_in,
   input  logic [TIME_W-1:0]            min_in,
   input  logic [TIME_W-1:0]            sec_in,
   input  logic [NUM_ALARMS*TIME_W-1:0] hour_ina,
   input  logic [NUM_ALARMS*TIME_W-1:0] minute_ina,
   input  logic [NUM_ALARMS-1:0]        alarm_enable,
   input  logic                         snooze,
   input  logic                         dismiss,
   output logic                         alarm,
   output logic [NUM_ALARMS-1:0]        ring_vec,
   output logic [NUM_ALARMS-1:0]        snooze_vec,
   output logic [NUM_ALARMS-1:0]        set,
   output logic [AW-1:0]                active_id
);

   localparam logic [1:0] ST_DIS  = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RING = 2'd2;
   localparam logic [1:0] ST_SNZ  = 2'd3;

   logic [1:0]          state_q [NUM_ALARMS];
   logic [1:0]          state_d [NUM_ALARMS];
   logic [CW-1:0]       cnt_q   [NUM_ALARMS];
   logic [CW-1:0]       cnt_d   [NUM_ALARMS];
   logic [SW-1:0]       scnt_q  [NUM_ALARMS];
   logic [SW-1:0]       scnt_d  [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] ring_d;
   logic [NUM_ALARMS-1:0] snz_d;
   logic [AW-1:0]       active_d;
   logic                hit;

   always_comb begin
      ring_d = '0;
      snz_d  = '0;
      hit    = 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         scnt_d[i]  = scnt_q[i];
         hit = tick && (sec_in == '0) &&
               (hour_in == hour_ina[i*TIME_W +: TIME_W]) &&
               (min_in == minute_ina[i*TIME_W +: TIME_W]);
         // Disable overrides every other request on this channel
         if (!alarm_enable[i]) begin
            state_d[i] = ST_DIS;
            cnt_d[i]   = '0;
            scnt_d[i]  = '0;
         end else begin
            unique case (state_q[i])
               ST_DIS: state_d[i] = ST_ARM;
               ST_ARM: begin
                  if (hit) begin
                     state_d[i] = ST_RING;
                     cnt_d[i]   = '0;
                     scnt_d[i]  = '0;
                  end
               end
               ST_RING: begin
                  if (dismiss) begin
                     state_d[i] = ST_ARM;
                     cnt_d[i]   = '0;
                  end else if (snooze && scnt_q[i] < SW'(MAX_SNOOZE)) begin
                     state_d[i] = ST_SNZ;
                     scnt_d[i]  = scnt_q[i] + SW'(1);
                     cnt_d[i]   = CW'(SNOOZE_SECS);
                  end else if (tick) begin
                     if (cnt_q[i] + CW'(1) == CW'(RING_TIMEOUT)) begin
                        state_d[i] = ST_ARM;
                        cnt_d[i]   = '0;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                     end
                  end
               end
               ST_SNZ: begin
                  if (dismiss) begin
                     state_d[i] = ST_ARM;
                     cnt_d[i]   = '0;
                  end else if (tick) begin
                     if (cnt_q[i] == CW'(1)) begin
                        state_d[i] = ST_RING;
                        cnt_d[i]   = '0;
                     end else begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                     end
                  end
               end
            endcase
         end
         ring_d[i] = (state_d[i] == ST_RING);
         snz_d[i]  = (state_d[i] == ST_SNZ);
      end
   end

   // Scan downward so the lowest ringing index wins
   always_comb begin
      active_d = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (ring_d[i]) active_d = AW'(i);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            state_q[i] <= ST_DIS;
            cnt_q[i]   <= '0;
            scnt_q[i]  <= '0;
         end
         alarm      <= 1'b0;
         ring_vec   <= '0;
         snooze_vec <= '0;
         set        <= '0;
         active_id  <= '0;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            scnt_q[i]  <= scnt_d[i];
         end
         alarm      <= |ring_d;
         ring_vec   <= ring_d;
         snooze_vec <= snz_d;
         set        <= alarm_enable;
         active_id  <= active_d;
      end
   end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: trigger, snooze limit, timeout,
// shared snooze/dismiss, disable priority and async reset.
module tb_alarm_bank;

   localparam int N  = 4;
   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tick = 1'b0;
   logic [TW-1:0] hour_in = '0;
   logic [TW-1:0] min_in = '0;
   logic [TW-1:0] sec_in = '0;
   logic [N*TW-1:0] hour_ina = '0;
   logic [N*TW-1:0] minute_ina = '0;
   logic [N-1:0]  alarm_enable = '0;
   logic          snooze = 1'b0;
   logic          dismiss = 1'b0;
   logic          alarm;
   logic [N-1:0]  ring_vec;
   logic [N-1:0]  snooze_vec;
   logic [N-1:0]  set;
   logic [1:0]    active_id;

   int errors = 0;
   int checks = 0;

   alarm_bank #(
      .NUM_ALARMS(N), .TIME_W(TW), .SNOOZE_SECS(5),
      .RING_TIMEOUT(10), .MAX_SNOOZE(2)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
      .hour_ina(hour_ina), .minute_ina(minute_ina),
      .alarm_enable(alarm_enable), .snooze(snooze), .dismiss(dismiss),
      .alarm(alarm), .ring_vec(ring_vec), .snooze_vec(snooze_vec),
      .set(set), .active_id(active_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] rv,
                          input logic [3:0] sv, input logic al,
                          input logic [1:0] aid);
      chk({tag, ".ring"}, {28'd0, ring_vec}, {28'd0, rv});
      chk({tag, ".snz"}, {28'd0, snooze_vec}, {28'd0, sv});
      chk({tag, ".alarm"}, {31'd0, alarm}, {31'd0, al});
      chk({tag, ".aid"}, {30'd0, active_id}, {30'd0, aid});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tk(input int s);
      sec_in = TW'(s);
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic pulse_snooze();
      snooze = 1'b1;
      step();
      snooze = 1'b0;
   endtask

   task automatic pulse_dismiss();
      dismiss = 1'b1;
      step();
      dismiss = 1'b0;
   endtask

   initial begin
      hour_ina[0*TW +: TW] = 6'd7;  minute_ina[0*TW +: TW] = 6'd30;
      hour_ina[1*TW +: TW] = 6'd8;  minute_ina[1*TW +: TW] = 6'd0;
      hour_ina[2*TW +: TW] = 6'd9;  minute_ina[2*TW +: TW] = 6'd0;
      hour_ina[3*TW +: TW] = 6'd10; minute_ina[3*TW +: TW] = 6'd0;
      #1 reset = 1'b1;
      step();
      step();
      chk_all("reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
      chk("reset.set", {28'd0, set}, 32'd0);
      reset = 1'b0;

      // ch0 at 07:30
      alarm_enable = 4'b0001;
      step();
      chk("arm0.set", {28'd0, set}, 32'h1);
      hour_in = 6'd7; min_in = 6'd30; sec_in = 6'd0;
      step();
      chk("notick", {28'd0, ring_vec}, 32'h0);
      tk(5);
      chk("sec_nz", {28'd0, ring_vec}, 32'h0);
      tk(0);
      chk_all("trig0", 4'b0001, 4'b0000, 1'b1, 2'd0);
      for (int s = 1; s <= 5; s++) tk(s);
      chk_all("hold0", 4'b0001, 4'b0000, 1'b1, 2'd0);
      pulse_dismiss();
      chk_all("dism0", 4'b0000, 4'b0000, 1'b0, 2'd0);
      tk(6);
      chk("noretrig", {28'd0, ring_vec}, 32'h0);

      // ch1 snooze limit
      alarm_enable = 4'b0011;
      step();
      hour_in = 6'd8; min_in = 6'd0;
      tk(0);
      chk_all("trig1", 4'b0010, 4'b0000, 1'b1, 2'd1);
      pulse_snooze();
      chk_all("snz1a", 4'b0000, 4'b0010, 1'b0, 2'd0);
      for (int s = 1; s <= 4; s++) tk(s);
      chk_all("snz1a_4t", 4'b0000, 4'b0010, 1'b0, 2'd0);
      tk(5);
      chk_all("rering1a", 4'b0010, 4'b0000, 1'b1, 2'd1);
      pulse_snooze();
      chk_all("snz1b", 4'b0000, 4'b0010, 1'b0, 2'd0);
      pulse_snooze();
      chk("snz_in_snz", {28'd0, snooze_vec}, 32'h2);
      for (int s = 6; s <= 10; s++) tk(s);
      chk_all("rering1b", 4'b0010, 4'b0000, 1'b1, 2'd1);
      pulse_snooze();
      chk_all("snz_limit", 4'b0010, 4'b0000, 1'b1, 2'd1);
      pulse_dismiss();
      chk_all("dism1", 4'b0000, 4'b0000, 1'b0, 2'd0);

      // ch2 ring timeout
      alarm_enable = 4'b0111;
      step();
      hour_in = 6'd9; min_in = 6'd0;
      tk(0);
      chk_all("trig2", 4'b0100, 4'b0000, 1'b1, 2'd2);
      for (int s = 1; s <= 9; s++) tk(s);
      chk_all("to_9", 4'b0100, 4'b0000, 1'b1, 2'd2);
      tk(10);
      chk_all("to_10", 4'b0000, 4'b0000, 1'b0, 2'd0);
      chk("to.set", {28'd0, set}, 32'h7);

      // ch0 and ch3 together, then snooze+dismiss
      hour_ina[0*TW +: TW] = 6'd6; minute_ina[0*TW +: TW] = 6'd0;
      hour_ina[3*TW +: TW] = 6'd6; minute_ina[3*TW +: TW] = 6'd0;
      alarm_enable = 4'b1111;
      step();
      hour_in = 6'd6; min_in = 6'd0;
      tk(0);
      chk_all("dual", 4'b1001, 4'b0000, 1'b1, 2'd0);
      snooze = 1'b1; dismiss = 1'b1;
      step();
      snooze = 1'b0; dismiss = 1'b0;
      chk_all("snzdism", 4'b0000, 4'b0000, 1'b0, 2'd0);

      // disable beats snooze
      hour_ina[3*TW +: TW] = 6'd10;
      tk(0);
      chk_all("trig0b", 4'b0001, 4'b0000, 1'b1, 2'd0);
      alarm_enable = 4'b1110;
      pulse_snooze();
      chk_all("dis_snz", 4'b0000, 4'b0000, 1'b0, 2'd0);
      chk("dis.set", {28'd0, set}, 32'he);

      // async reset mid-snooze
      alarm_enable = 4'b0001;
      step();
      tk(0);
      chk("trig0c", {28'd0, ring_vec}, 32'h1);
      pulse_snooze();
      chk("snz0c", {28'd0, snooze_vec}, 32'h1);
      #3 reset = 1'b1;
      #1;
      chk_all("async", 4'b0000, 4'b0000, 1'b0, 2'd0);
      chk("async.set", {28'd0, set}, 32'h0);
      step();
      reset = 1'b0;
      step();
      chk("rearm.set", {28'd0, set}, 32'h1);
      tk(0);
      chk_all("postrst", 4'b0001, 4'b0000, 1'b1, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
